// File: rtl/cim_bus_rx_if.sv
// Bus seen by every CiM receive endpoint: opcode, destination and three payload words.
interface cim_bus_rx_if #(
    parameter int unsigned NUM_CIMS     = 64,
    parameter int unsigned N_STORAGE    = 16,
    parameter int unsigned BUS_OP_WIDTH = 3
);
    localparam int unsigned TGT_W = (NUM_CIMS > 1) ? $clog2(NUM_CIMS) : 1;

    logic [BUS_OP_WIDTH-1:0]     bus_op;
    logic signed [N_STORAGE-1:0] bus_data [3];
    logic [TGT_W-1:0]            bus_target_or_sender;

    modport master (output bus_op, output bus_data, output bus_target_or_sender);
    modport slave  (input  bus_op, input  bus_data, input  bus_target_or_sender);
endinterface

// File: rtl/cim_bus_rx.sv
// Per-CiM bus responder: serializes parameter streams into memory writes and captures this
// CiM's patch samples. Define CIM_BUS_RX_STATS_EN to add saturating activity counters.
module cim_bus_rx #(
    parameter int unsigned ID           = 0,
    parameter int unsigned NUM_CIMS     = 64,
    parameter int unsigned N_STORAGE    = 16,
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned PATCH_LEN    = 64,
    parameter int unsigned NUM_PATCHES  = 60,
    parameter int unsigned PATCH_BASE   = 0,
    parameter int unsigned BUS_OP_WIDTH = 3,
    localparam int unsigned ADDR_W      = $clog2(MEM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cim_bus_rx_if.slave                 i_bus,
    output logic                        o_mem_wr_en,
    output logic [ADDR_W-1:0]           o_mem_wr_addr,
    output logic signed [N_STORAGE-1:0] o_mem_wr_data,
    output logic                        o_pistol_start,
    output logic                        o_is_ready,
    output logic                        o_err_overrun
`ifdef CIM_BUS_RX_STATS_EN
    ,
    output logic [15:0]                 o_stat_words_written,
    output logic [15:0]                 o_stat_ops_decoded
`endif
);
    localparam int unsigned TGT_W    = (NUM_CIMS > 1) ? $clog2(NUM_CIMS) : 1;
    localparam int unsigned TOTAL    = NUM_PATCHES * PATCH_LEN;
    localparam int unsigned SAMPLE_W = $clog2(TOTAL + 1);
    localparam int unsigned PATCH_LO = ID * PATCH_LEN;

    localparam logic [BUS_OP_WIDTH-1:0] OP_NOP         = BUS_OP_WIDTH'(0);
    localparam logic [BUS_OP_WIDTH-1:0] OP_STREAM_START = BUS_OP_WIDTH'(1);
    localparam logic [BUS_OP_WIDTH-1:0] OP_STREAM      = BUS_OP_WIDTH'(2);
    localparam logic [BUS_OP_WIDTH-1:0] OP_PATCH_START = BUS_OP_WIDTH'(3);
    localparam logic [BUS_OP_WIDTH-1:0] OP_PATCH       = BUS_OP_WIDTH'(4);
    localparam logic [BUS_OP_WIDTH-1:0] OP_PISTOL      = BUS_OP_WIDTH'(5);

    typedef enum logic [1:0] {StIdle, StParam, StPatch} state_e;

    state_e                      r_state, w_state_d;
    logic [ADDR_W-1:0]           r_wr_ptr, w_wr_ptr_d, w_wr_ptr_inc;
    logic [N_STORAGE-1:0]        r_remaining, w_remaining_d;
    logic signed [N_STORAGE-1:0] r_buf [3];
    logic signed [N_STORAGE-1:0] w_buf_d [3];
    logic [1:0]                  r_buf_cnt, w_buf_cnt_d, r_buf_idx, w_buf_idx_d, w_take;
    logic [SAMPLE_W-1:0]         r_sample_idx, w_sample_idx_d;
    logic                        r_mem_wr_en, w_mem_wr_en_d;
    logic [ADDR_W-1:0]           r_mem_wr_addr, w_mem_wr_addr_d;
    logic signed [N_STORAGE-1:0] r_mem_wr_data, w_mem_wr_data_d;
    logic                        r_pistol, r_is_ready, w_is_ready_d, r_err, w_err_d;
    logic                        w_op_start, w_op_data, w_op_pstart, w_op_psample, w_op_pistol;
    logic                        w_to_me, w_accept;
    logic [31:0]                 w_patch_off;

    // Unknown or unassigned opcodes fall through to the default and behave as NOP.
    always_comb begin
        w_op_start   = 1'b0;
        w_op_data    = 1'b0;
        w_op_pstart  = 1'b0;
        w_op_psample = 1'b0;
        w_op_pistol  = 1'b0;
        case (i_bus.bus_op)
            OP_STREAM_START: w_op_start   = 1'b1;
            OP_STREAM:       w_op_data    = 1'b1;
            OP_PATCH_START:  w_op_pstart  = 1'b1;
            OP_PATCH:        w_op_psample = 1'b1;
            OP_PISTOL:       w_op_pistol  = 1'b1;
            OP_NOP:          ;
            default:         ;
        endcase
    end

    assign w_to_me      = (i_bus.bus_target_or_sender == TGT_W'(ID));
    assign w_wr_ptr_inc = (r_wr_ptr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_take       = (r_remaining >= N_STORAGE'(3)) ? 2'd3 : r_remaining[1:0];
    // Unsigned offset wraps for samples below this patch, so one compare covers both bounds.
    assign w_patch_off  = 32'(r_sample_idx) - PATCH_LO;

    always_comb begin
        w_state_d       = r_state;
        w_wr_ptr_d      = r_wr_ptr;
        w_remaining_d   = r_remaining;
        w_buf_d         = r_buf;
        w_buf_cnt_d     = r_buf_cnt;
        w_buf_idx_d     = r_buf_idx;
        w_sample_idx_d  = r_sample_idx;
        w_mem_wr_en_d   = 1'b0;
        w_mem_wr_addr_d = r_mem_wr_addr;
        w_mem_wr_data_d = r_mem_wr_data;
        w_err_d         = r_err;
        w_accept        = w_op_pistol;

        if ((r_state != StPatch) && w_op_start && w_to_me) begin
            w_accept      = 1'b1;
            w_wr_ptr_d    = i_bus.bus_data[0][ADDR_W-1:0];
            w_remaining_d = i_bus.bus_data[1];
            w_buf_cnt_d   = 2'd0;
            w_buf_idx_d   = 2'd0;
            w_state_d     = (i_bus.bus_data[1] != '0) ? StParam : StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_op_pstart) begin
                        w_accept       = 1'b1;
                        w_sample_idx_d = '0;
                        w_state_d      = StPatch;
                    end
                end
                StParam: begin
                    if (r_buf_cnt != 2'd0) begin
                        w_mem_wr_en_d   = 1'b1;
                        w_mem_wr_addr_d = r_wr_ptr;
                        w_mem_wr_data_d = r_buf[r_buf_idx];
                        w_buf_idx_d     = r_buf_idx + 2'd1;
                        w_buf_cnt_d     = r_buf_cnt - 2'd1;
                        if (w_op_data && w_to_me) w_err_d = 1'b1;
                    end else if (w_op_data && w_to_me) begin
                        // Word 0 goes straight out; the rest wait in the holding buffer.
                        w_accept        = 1'b1;
                        w_mem_wr_en_d   = 1'b1;
                        w_mem_wr_addr_d = r_wr_ptr;
                        w_mem_wr_data_d = i_bus.bus_data[0];
                        w_buf_d         = i_bus.bus_data;
                        w_buf_idx_d     = 2'd1;
                        w_buf_cnt_d     = w_take - 2'd1;
                    end
                    if (w_mem_wr_en_d) begin
                        w_wr_ptr_d    = w_wr_ptr_inc;
                        w_remaining_d = r_remaining - 1'b1;
                        if (r_remaining == N_STORAGE'(1)) begin
                            w_state_d   = StIdle;
                            w_buf_cnt_d = 2'd0;
                        end
                    end
                end
                StPatch: begin
                    if (w_op_psample) begin
                        w_accept       = 1'b1;
                        w_sample_idx_d = r_sample_idx + 1'b1;
                        if (w_patch_off < PATCH_LEN) begin
                            w_mem_wr_en_d   = 1'b1;
                            w_mem_wr_addr_d = ADDR_W'(PATCH_BASE + w_patch_off);
                            w_mem_wr_data_d = i_bus.bus_data[0];
                        end
                        if (32'(r_sample_idx) == TOTAL - 1) w_state_d = StIdle;
                    end else if (w_op_start || w_op_data || w_op_pstart) begin
                        w_err_d   = 1'b1;
                        w_state_d = StIdle;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
        w_is_ready_d = (w_state_d == StIdle) && !w_mem_wr_en_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_wr_ptr      <= '0;
            r_remaining   <= '0;
            r_buf         <= '{default: '0};
            r_buf_cnt     <= 2'd0;
            r_buf_idx     <= 2'd0;
            r_sample_idx  <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
            r_pistol      <= 1'b0;
            r_is_ready    <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_wr_ptr      <= w_wr_ptr_d;
            r_remaining   <= w_remaining_d;
            r_buf         <= w_buf_d;
            r_buf_cnt     <= w_buf_cnt_d;
            r_buf_idx     <= w_buf_idx_d;
            r_sample_idx  <= w_sample_idx_d;
            r_mem_wr_en   <= w_mem_wr_en_d;
            r_mem_wr_addr <= w_mem_wr_addr_d;
            r_mem_wr_data <= w_mem_wr_data_d;
            r_pistol      <= w_op_pistol;
            r_is_ready    <= w_is_ready_d;
            r_err         <= w_err_d;
        end
    end

    assign o_mem_wr_en    = r_mem_wr_en;
    assign o_mem_wr_addr  = r_mem_wr_addr;
    assign o_mem_wr_data  = r_mem_wr_data;
    assign o_pistol_start = r_pistol;
    assign o_is_ready     = r_is_ready;
    assign o_err_overrun  = r_err;

`ifdef CIM_BUS_RX_STATS_EN
    logic [15:0] r_stat_words, r_stat_ops;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_words <= '0;
            r_stat_ops   <= '0;
        end else begin
            if (w_mem_wr_en_d && (r_stat_words != 16'hFFFF)) r_stat_words <= r_stat_words + 16'd1;
            if (w_accept && (r_stat_ops != 16'hFFFF)) r_stat_ops <= r_stat_ops + 16'd1;
        end
    end

    assign o_stat_words_written = r_stat_words;
    assign o_stat_ops_decoded   = r_stat_ops;
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif
endmodule

// File: tb/tb_cim_bus_rx.sv
// Two endpoints (ID 1 and ID 3) share one bus; every cycle both are compared against a
// transaction-level model, with directed scenarios followed by random traffic.
module tb_cim_bus_rx;
    localparam logic [2:0] NOP      = 3'd0;
    localparam logic [2:0] DS_START = 3'd1;
    localparam logic [2:0] DS       = 3'd2;
    localparam logic [2:0] PL_START = 3'd3;
    localparam logic [2:0] PL       = 3'd4;
    localparam logic [2:0] PISTOL   = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cim_bus_rx_if #(.NUM_CIMS(4), .N_STORAGE(16), .BUS_OP_WIDTH(3)) bus ();

    logic               a_wr_en, b_wr_en, a_pistol, b_pistol, a_ready, b_ready, a_err, b_err;
    logic [6:0]         a_wr_addr, b_wr_addr;
    logic signed [15:0] a_wr_data, b_wr_data;
`ifdef CIM_BUS_RX_STATS_EN
    logic [15:0]        a_stat_w, a_stat_o, b_stat_w, b_stat_o;
`endif

    cim_bus_rx #(
        .ID(1), .NUM_CIMS(4), .N_STORAGE(16), .MEM_DEPTH(128), .PATCH_LEN(4),
        .NUM_PATCHES(3), .PATCH_BASE(8), .BUS_OP_WIDTH(3)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .i_bus(bus),
        .o_mem_wr_en(a_wr_en), .o_mem_wr_addr(a_wr_addr), .o_mem_wr_data(a_wr_data),
        .o_pistol_start(a_pistol), .o_is_ready(a_ready), .o_err_overrun(a_err)
`ifdef CIM_BUS_RX_STATS_EN
        , .o_stat_words_written(a_stat_w), .o_stat_ops_decoded(a_stat_o)
`endif
    );

    cim_bus_rx #(
        .ID(3), .NUM_CIMS(4), .N_STORAGE(16), .MEM_DEPTH(128), .PATCH_LEN(4),
        .NUM_PATCHES(3), .PATCH_BASE(8), .BUS_OP_WIDTH(3)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .i_bus(bus),
        .o_mem_wr_en(b_wr_en), .o_mem_wr_addr(b_wr_addr), .o_mem_wr_data(b_wr_data),
        .o_pistol_start(b_pistol), .o_is_ready(b_ready), .o_err_overrun(b_err)
`ifdef CIM_BUS_RX_STATS_EN
        , .o_stat_words_written(b_stat_w), .o_stat_ops_decoded(b_stat_o)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Model: mode 0 idle, 1 parameter stream, 2 patch load.
    int          m_mode [2];
    int          m_rem [2];
    int          m_base [2];
    int          m_k [2];
    int          m_sample [2];
    bit          m_err [2];
    logic [15:0] m_pend [2][$];
    bit          e_wr [2];
    int          e_addr [2];
    logic [15:0] e_data [2];
    bit          e_pistol [2];
    bit          e_ready [2];

    logic [15:0] mem_a [128];
    logic [15:0] mem_b [128];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic [2:0] op, input logic [1:0] tgt,
                              input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2);
        logic [15:0] dw [3];
        dw = '{d0, d1, d2};
        for (int i = 0; i < 2; i++) begin
            int id;
            bit to_me;
            id = (i == 0) ? 1 : 3;
            to_me = (int'(tgt) == id);
            e_wr[i] = 1'b0;
            e_pistol[i] = 1'b0;
            if (!rst_v) begin
                m_mode[i] = 0; m_rem[i] = 0; m_k[i] = 0; m_sample[i] = 0; m_err[i] = 1'b0;
                m_pend[i].delete();
                e_addr[i] = 0;
                e_data[i] = 16'h0;
            end else begin
                e_pistol[i] = (op === PISTOL);
                if (m_mode[i] != 2 && op === DS_START && to_me) begin
                    m_pend[i].delete();
                    m_rem[i] = int'(d1);
                    m_base[i] = int'(d0) % 128;
                    m_k[i] = 0;
                    m_mode[i] = (m_rem[i] != 0) ? 1 : 0;
                end else if (m_mode[i] == 1) begin
                    if (op === DS && to_me) begin
                        if (m_pend[i].size() != 0) m_err[i] = 1'b1;
                        else for (int w = 0; w < 3 && w < m_rem[i]; w++) m_pend[i].push_back(dw[w]);
                    end
                    if (m_pend[i].size() != 0) begin
                        e_wr[i] = 1'b1;
                        e_data[i] = m_pend[i].pop_front();
                        e_addr[i] = (m_base[i] + m_k[i]) % 128;
                        m_k[i]++;
                        m_rem[i]--;
                        if (m_rem[i] == 0) m_mode[i] = 0;
                    end
                end else if (m_mode[i] == 0 && op === PL_START) begin
                    m_sample[i] = 0;
                    m_mode[i] = 2;
                end else if (m_mode[i] == 2) begin
                    if (op === PL) begin
                        if (m_sample[i] >= id * 4 && m_sample[i] < (id + 1) * 4) begin
                            e_wr[i] = 1'b1;
                            e_addr[i] = 8 + m_sample[i] - id * 4;
                            e_data[i] = d0;
                        end
                        m_sample[i]++;
                        if (m_sample[i] == 12) m_mode[i] = 0;
                    end else if (op === DS_START || op === DS || op === PL_START) begin
                        m_err[i] = 1'b1;
                        m_mode[i] = 0;
                    end
                end
            end
            e_ready[i] = (m_mode[i] == 0) && !e_wr[i];
        end
    endtask

    task automatic step(input logic rst_v, input logic [2:0] op, input logic [1:0] tgt,
                        input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        logic        o_wr [2];
        logic [6:0]  o_addr [2];
        logic [15:0] o_data [2];
        logic        o_pis [2];
        logic        o_rdy [2];
        logic        o_err [2];
        @(negedge clk);
        rst_n = rst_v;
        bus.bus_op = op;
        bus.bus_target_or_sender = tgt;
        bus.bus_data[0] = d0;
        bus.bus_data[1] = d1;
        bus.bus_data[2] = d2;
        @(posedge clk);
        model_edge(rst_v, op, tgt, d0, d1, d2);
        #1;
        o_wr = '{a_wr_en, b_wr_en};
        o_addr = '{a_wr_addr, b_wr_addr};
        o_data = '{a_wr_data, b_wr_data};
        o_pis = '{a_pistol, b_pistol};
        o_rdy = '{a_ready, b_ready};
        o_err = '{a_err, b_err};
        if (a_wr_en === 1'b1) mem_a[a_wr_addr] = a_wr_data;
        if (b_wr_en === 1'b1) mem_b[b_wr_addr] = b_wr_data;
        for (int i = 0; i < 2; i++) begin
            string p;
            p = (i == 0) ? "a" : "b";
            check({p, "_wr_en"}, 16'(o_wr[i]), 16'(e_wr[i]));
            if (e_wr[i] || !rst_v) begin
                check({p, "_wr_addr"}, 16'(o_addr[i]), 16'(e_addr[i]));
                check({p, "_wr_data"}, o_data[i], e_data[i]);
            end
            check({p, "_pistol"}, 16'(o_pis[i]), 16'(e_pistol[i]));
            check({p, "_ready"}, 16'(o_rdy[i]), 16'(e_ready[i]));
            check({p, "_err"}, 16'(o_err[i]), 16'(m_err[i]));
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [1:0] tgt, input logic [15:0] d0,
                         input logic [15:0] d1, input logic [15:0] d2);
        step(1'b1, op, tgt, d0, d1, d2);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b1, NOP, 2'd0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        for (int j = 0; j < 128; j++) begin
            mem_a[j] = 16'hDEAD;
            mem_b[j] = 16'hDEAD;
        end
        step(1'b0, NOP, 2'd0, 16'h0, 16'h0, 16'h0);
        step(1'b0, NOP, 2'd0, 16'h0, 16'h0, 16'h0);
        idle(2);

        // Param stream to ID 3: five words from two ops, last word of the second dropped.
        drive(DS_START, 2'd3, 16'd100, 16'd5, 16'd0);
        idle(1);
        drive(DS, 2'd3, 16'd11, 16'd12, 16'd13);
        idle(3);
        drive(DS, 2'd3, 16'd14, 16'd15, 16'd16);
        idle(4);
        for (int j = 0; j < 5; j++) check("b_mem_stream", mem_b[100 + j], 16'(11 + j));
        check("b_mem_dropped", mem_b[105], 16'hDEAD);

        // Same sequence to an absent target.
        drive(DS_START, 2'd2, 16'd100, 16'd5, 16'd0);
        drive(DS, 2'd2, 16'd11, 16'd12, 16'd13);
        idle(3);
        drive(DS, 2'd2, 16'd14, 16'd15, 16'd16);
        idle(3);

        // Overrun: second op while two words are still buffered.
        drive(DS_START, 2'd3, 16'd20, 16'd6, 16'd0);
        drive(DS, 2'd3, 16'd1, 16'd2, 16'd3);
        drive(DS, 2'd3, 16'd4, 16'd5, 16'd6);
        idle(4);
        check("b_mem_overrun", mem_b[23], 16'hDEAD);

        // Restart mid-stream, then reset between the first and second drain writes.
        drive(DS_START, 2'd3, 16'd40, 16'd5, 16'd0);
        drive(DS, 2'd3, 16'd7, 16'd8, 16'd9);
        step(1'b0, NOP, 2'd0, 16'h0, 16'h0, 16'h0);
        idle(4);
        check("b_mem_after_rst", mem_b[41], 16'hDEAD);

        // Patch load with a pistol pulse in the middle.
        drive(PL_START, 2'd0, 16'h0, 16'h0, 16'h0);
        for (int s = 0; s < 12; s++) begin
            if (s == 6) drive(PISTOL, 2'd2, 16'h0, 16'h0, 16'h0);
            drive(PL, 2'd0, 16'(10 + s), 16'h0, 16'h0);
        end
        idle(2);
        for (int j = 0; j < 4; j++) check("a_mem_patch", mem_a[8 + j], 16'(14 + j));
        check("a_mem_patch_end", mem_a[12], 16'hDEAD);

        // Address wrap at the top of memory.
        drive(DS_START, 2'd1, 16'd126, 16'd4, 16'd0);
        drive(DS, 2'd1, 16'h1111, 16'h2222, 16'h3333);
        idle(3);
        drive(DS, 2'd1, 16'h4444, 16'h5555, 16'h6666);
        idle(3);
        check("a_mem_wrap0", mem_a[0], 16'h3333);
        check("a_mem_wrap1", mem_a[1], 16'h4444);
        check("a_mem_wrap2", mem_a[2], 16'hDEAD);

        for (int n = 0; n < 800; n++) begin
            int          r;
            logic        rst_v;
            logic [2:0]  op;
            r = int'($urandom_range(0, 99));
            rst_v = 1'b1;
            if (r < 30) op = NOP;
            else if (r < 40) op = DS_START;
            else if (r < 58) op = DS;
            else if (r < 63) op = PL_START;
            else if (r < 85) op = PL;
            else if (r < 91) op = PISTOL;
            else if (r < 97) op = 3'(6 + (r % 2));
            else begin
                op = NOP;
                rst_v = 1'b0;
            end
            step(rst_v, op, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 7)),
                 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cim_bus_rx.md
Name: cim_bus_rx

Overview:
- Receive-side bus endpoint instantiated once per CiM; the responder to the master's bus transactions.
- Decodes bus_op / bus_target_or_sender / bus_data each cycle.
- Parameter streams: DATA_STREAM_START_OP followed by DATA_STREAM_OP, 3 words per op. Serialized into single-word writes to the CiM parameter memory.
- Patch broadcasts: only the EEG samples belonging to this CiM's patch are written into its patch buffer. PISTOL_START_OP is forwarded as a start pulse.

Parameters:
- ID, 0, CiM index matched against bus_target_or_sender.
- NUM_CIMS, 64, number of CiMs; sets target width.
- N_STORAGE, 16, storage word width.
- MEM_DEPTH, 1024, words in the local memory; ADDR_W = $clog2(MEM_DEPTH).
- PATCH_LEN, 64, samples per patch.
- NUM_PATCHES, 60, patches per epoch.
- PATCH_BASE, 0, memory address of patch element 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- bus_op  in  BUS_OP_WIDTH  bus opcode (BUS_OP_T)
- bus_data  in  3 x N_STORAGE signed  bus payload words [0..2]
- bus_target_or_sender  in  $clog2(NUM_CIMS)  destination CiM
- mem_wr_en  out  1  write strobe
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  N_STORAGE signed  write data
- pistol_start  out  1  one-cycle compute-start pulse
- is_ready  out  1  high when idle and nothing is pending; feeds all_cims_ready
- err_overrun  out  1  sticky error flag, cleared only by reset

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0 except is_ready=1; state IDLE; counters 0; holding buffer empty.
- Input sampling: bus inputs are sampled every posedge. An X/Z bus_op (bus undriven) is treated as NOP.
- State IDLE:
  - DATA_STREAM_START_OP with target==ID: latch start_addr=bus_data[0][ADDR_W-1:0] and remaining=bus_data[1]; enter PARAM_STREAM; is_ready=0 next cycle.
  - remaining==0: stay IDLE, issue no writes.
  - PATCH_LOAD_BROADCAST_START_OP (any target): sample_idx=0; enter PATCH_LOAD; is_ready=0.
- State PARAM_STREAM:
  - DATA_STREAM_OP with target==ID: load bus_data[0..2] into the 3-entry holding buffer.
  - Drain one word per cycle, starting the cycle after the op is sampled: mem_wr_en=1, mem_wr_addr=start_addr+k, k increments per written word.
  - Only min(3, remaining) words are written; the rest are discarded.
  - remaining reaches 0 after the last write: return to IDLE; is_ready=1 on the following cycle.
  - DATA_STREAM_OP to ID while the buffer still holds undrained words: set err_overrun; drop the new op; the drain continues.
  - DATA_STREAM_START_OP to ID mid-stream: abort the current stream (flush the buffer) and restart with the new parameters.
  - Ops targeting another CiM are ignored.
- State PATCH_LOAD:
  - Each PATCH_LOAD_BROADCAST_OP: sample_idx increments.
  - Write condition: ID*PATCH_LEN <= sample_idx < (ID+1)*PATCH_LEN. Write mem_wr_data=bus_data[0] to PATCH_BASE + sample_idx - ID*PATCH_LEN, one cycle after the op.
  - NOP cycles are ignored.
  - After sample NUM_PATCHES*PATCH_LEN-1 is received: return to IDLE.
  - Any other op: set err_overrun, return to IDLE.
  - ID >= NUM_PATCHES: the CiM never writes, but still tracks the count.
- PISTOL_START_OP (any target, any state): pistol_start=1 for exactly the next cycle. It does not change the state.
- Address arithmetic: start_addr+k wraps modulo MEM_DEPTH; no error is raised.
- Reset mid-stream: no further writes after the reset edge; the buffer is cleared.

Optional Feature:
- Macro: CIM_BUS_RX_STATS_EN.
- Defined:
  - Adds outputs stat_words_written[15:0] and stat_ops_decoded[15:0].
  - Both counters saturate at 16'hFFFF and reset to 0.
  - stat_ops_decoded counts non-NOP ops accepted by this endpoint.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Param stream: ID=3. START(target 3, data 100,5), then DATA_STREAM_OP(3: 11,12,13) and, 4 cycles later, (3: 14,15,16). Required: writes addr100..104 = 11..15, 16 never written, is_ready=0 during the stream and 1 one cycle after the write to 104.
- Wrong target: the same sequence with target=4. Required: no mem_wr_en, is_ready stays 1.
- Overrun: a second DATA_STREAM_OP one cycle after the first. Required: err_overrun=1; only the first op's 3 words are written.
- Patch load: ID=1, PATCH_LEN=4, NUM_PATCHES=3. Broadcast START, then samples 0..11 with values 10..21. Required: PATCH_BASE+0..3 = 14..17; state returns IDLE after sample 11.
- Pistol start: PISTOL_START_OP during PATCH_LOAD. Required: single-cycle pulse one cycle later; the patch load continues.
- Reset mid-stream: rst_n low for one cycle between the 1st and 2nd drain write. Required: no further writes; is_ready=1 and err_overrun=0 after reset.
